// File: rtl/mips_tb_checker_if.sv
// Bus between the self-check harness and its driver: expected-value loading,
// CPU result observation and verdict outputs.
interface mips_tb_checker_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int AW = $clog2(DEPTH);

    logic              exp_wr;
    logic [DATA_W-1:0] exp_data;
    logic              start;
    logic [DATA_W-1:0] resultado;
    logic              cpu_run;
    logic              done;
    logic              pass;
    logic [1:0]        status;
    logic [AW:0]       match_cnt;
    logic [DATA_W-1:0] err_value;
    logic [AW-1:0]     err_index;

    modport master (
        output exp_wr, exp_data, start, resultado,
        input  cpu_run, done, pass, status, match_cnt, err_value, err_index
    );

    modport slave (
        input  exp_wr, exp_data, start, resultado,
        output cpu_run, done, pass, status, match_cnt, err_value, err_index
    );
endinterface

// File: rtl/mips_tb_checker.sv
// On-chip result checker: watches a CPU result bus for changes and matches them
// in order against a loaded table. Define MIPS_TB_ERRCAP_EN to capture the mismatch.
module mips_tb_checker #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clkTB,
    input  logic             rstTB_n,
    mips_tb_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     match_cnt_q, match_cnt_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] tbl_q [DEPTH];
    logic              tbl_we;
    logic              evt;
    logic              hit;

    assign evt = (bus.resultado != prev_q);
    assign hit = (bus.resultado == tbl_q[rd_ptr_q[AW-1:0]]);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        match_cnt_d = match_cnt_q;
        wdog_d      = wdog_q;
        prev_d      = prev_q;
        tbl_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.exp_wr && (wr_ptr_q != CW'(DEPTH))) begin
                    tbl_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + CW'(1);
                end
                // A write in the start cycle is already counted in wr_ptr_d.
                if (bus.start) begin
                    if (wr_ptr_d == '0) begin
                        state_d = S_PASS;
                    end else begin
                        state_d     = S_RUN;
                        prev_d      = bus.resultado;
                        rd_ptr_d    = '0;
                        match_cnt_d = '0;
                        wdog_d      = '0;
                    end
                end
            end
            S_RUN: begin
                if (evt) begin
                    prev_d = bus.resultado;
                    if (hit) begin
                        rd_ptr_d    = rd_ptr_q + CW'(1);
                        match_cnt_d = match_cnt_q + CW'(1);
                        wdog_d      = '0;
                        if ((match_cnt_q + CW'(1)) == wr_ptr_q) state_d = S_PASS;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    state_d = S_TMO;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkTB or negedge rstTB_n) begin
        if (!rstTB_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            match_cnt_q <= '0;
            wdog_q      <= '0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            match_cnt_q <= match_cnt_d;
            wdog_q      <= wdog_d;
            prev_q      <= prev_d;
        end
    end

    // Table storage carries no reset; wr_ptr alone decides which entries are live.
    always_ff @(posedge clkTB) begin
        if (tbl_we) tbl_q[wr_ptr_q[AW-1:0]] <= bus.exp_data;
    end

`ifdef MIPS_TB_ERRCAP_EN
    logic [DATA_W-1:0] err_value_q, err_value_d;
    logic [AW-1:0]     err_index_q, err_index_d;

    always_comb begin
        err_value_d = err_value_q;
        err_index_d = err_index_q;
        if ((state_q == S_RUN) && evt && !hit) begin
            err_value_d = bus.resultado;
            err_index_d = rd_ptr_q[AW-1:0];
        end
    end

    always_ff @(posedge clkTB or negedge rstTB_n) begin
        if (!rstTB_n) begin
            err_value_q <= '0;
            err_index_q <= '0;
        end else begin
            err_value_q <= err_value_d;
            err_index_q <= err_index_d;
        end
    end

    assign bus.err_value = err_value_q;
    assign bus.err_index = err_index_q;
`else
    assign bus.err_value = '0;
    assign bus.err_index = '0;
`endif

    assign bus.cpu_run   = (state_q == S_RUN);
    assign bus.done      = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TMO);
    assign bus.pass      = (state_q == S_PASS);
    assign bus.match_cnt = match_cnt_q;

    always_comb begin
        case (state_q)
            S_PASS:  bus.status = 2'b01;
            S_FAIL:  bus.status = 2'b10;
            S_TMO:   bus.status = 2'b11;
            default: bus.status = 2'b00;
        endcase
    end
endmodule
